shift_add_multiplier: RTL and testbench

Sequential unsigned shift-add multiplier with optional accumulate: computes `o_product = i_multiplicand * i_multiplier (+ i_addend)`, one multiplier bit per clock. It is the inverse companion to the team's sequential restoring divider and sits in the same fixed-point datapath. Typical uses are rebuilding a dividend as `quotient * denominator + remainder` and rescaling activations. It uses one adder and no hard DSP multiplier, and its latency is fixed and independent of the data.

---
 rtl/shift_add_multiplier.sv | 133 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-add multiplier with optional accumulate
//
// Computes o_product = i_multiplicand * i_multiplier (+ i_addend), one multiplier
// bit per clock, using a single adder. Latency is fixed at W_B + 2 cycles from
// accept to the o_mul_valid pulse, regardless of operand values.
//
// Build option: define SHIFT_ADD_MULT_ACC_EN to preload the accumulator with
// i_addend (product = A*B + C). Without it the accumulator starts at zero and
// i_addend is left unconnected.
//
// Ports:
//   i_sclk          clock, rising edge
//   i_rstp          synchronous active-high reset
//   i_mul_valid     request strobe, accepted only while o_ready is high
//   i_multiplicand  operand A, W_A bits
//   i_multiplier    operand B, W_B bits
//   i_addend        addend C, W_C bits (W_C <= W_A)
//   o_ready         high in IDLE
//   o_mul_valid     one-cycle result strobe
//   o_product       result, W_P bits, held until the next result

module shift_add_multiplier #(
  parameter int W_A = 8,
  parameter int W_B = 8,
  parameter int W_C = W_A,
  parameter int W_P = W_A + W_B
) (
  input  logic           i_sclk,
  input  logic           i_rstp,
  input  logic           i_mul_valid,
  input  logic [W_A-1:0] i_multiplicand,
  input  logic [W_B-1:0] i_multiplier,
  input  logic [W_C-1:0] i_addend,
  output logic           o_ready,
  output logic           o_mul_valid,
  output logic [W_P-1:0] o_product
);

  localparam int CNT_W = $clog2(W_B + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [W_P-1:0]   a_q, a_d;
  logic [W_B-1:0]   b_q, b_d;
  logic [W_P-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W_P-1:0]   product_q, product_d;
  logic             mul_valid_q, mul_valid_d;
  logic [W_P-1:0]   acc_init;

`ifdef SHIFT_ADD_MULT_ACC_EN
  assign acc_init = {{(W_P - W_C){1'b0}}, i_addend};
`else
  // Addend is not part of this build; the reduction only marks it as consumed.
  logic unused_addend;
  assign unused_addend = ^i_addend;
  assign acc_init      = '0;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    mul_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_mul_valid) begin
          a_d     = {{(W_P - W_A){1'b0}}, i_multiplicand};
          b_d     = i_multiplier;
          acc_d   = acc_init;
          cnt_d   = CNT_W'(W_B);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Add the shifted multiplicand when the current multiplier LSB is set;
        // no early exit on zero operands keeps latency data-independent.
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d   = acc_q;
        mul_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        // Any non one-hot encoding recovers to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sclk) begin
    if (i_rstp) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      mul_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      mul_valid_q <= mul_valid_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_mul_valid = mul_valid_q;
  assign o_product   = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed-vector bench for shift_add_multiplier

module tb_shift_add_multiplier;

`ifdef SHIFT_ADD_MULT_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        i_sclk = 1'b0;
  logic        i_rstp;
  logic        i_mul_valid;
  logic [7:0]  i_multiplicand;
  logic [7:0]  i_multiplier;
  logic [7:0]  i_addend;
  logic        o_ready;
  logic        o_mul_valid;
  logic [15:0] o_product;

  int n_vec  = 0;
  int n_miss = 0;

  shift_add_multiplier dut (
    .i_sclk         (i_sclk),
    .i_rstp         (i_rstp),
    .i_mul_valid    (i_mul_valid),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_addend       (i_addend),
    .o_ready        (o_ready),
    .o_mul_valid    (o_mul_valid),
    .o_product      (o_product)
  );

  always #5 i_sclk = ~i_sclk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  // Called in cycle T+start; steps until o_mul_valid is seen (bounded) and
  // returns its cycle offset from T, plus whether o_ready stayed low meanwhile.
  task automatic wait_result(input int start, output int lat, output bit busy_ok);
    lat     = start;
    busy_ok = 1'b1;
    while (!o_mul_valid && lat < 30) begin
      if (o_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  // Present a request in the current cycle (o_ready expected high) and check
  // latency, busy window and result. Returns in cycle T+10 (o_mul_valid high).
  task automatic mul_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input int exp_off, input int exp_on, input string tag);
    int lat;
    bit busy_ok;
    i_multiplicand = a;
    i_multiplier   = b;
    i_addend       = c;
    i_mul_valid    = 1'b1;
    tick();
    i_mul_valid    = 1'b0;
    i_multiplicand = ~a;
    i_multiplier   = ~b;
    i_addend       = ~c;
    wait_result(1, lat, busy_ok);
    check({tag, " latency"}, lat, 10);
    check({tag, " busy"}, int'(busy_ok), 1);
    check({tag, " product"}, int'(o_product), ACC ? exp_on : exp_off);
    check({tag, " ready"}, int'(o_ready), 1);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int pulses;

    i_rstp         = 1'b1;
    i_mul_valid    = 1'b0;
    i_multiplicand = '0;
    i_multiplier   = '0;
    i_addend       = '0;
    repeat (3) tick();
    i_rstp = 1'b0;
    check("reset ready", int'(o_ready), 1);
    check("reset valid", int'(o_mul_valid), 0);
    check("reset product", int'(o_product), 0);

    // A*B and A*B+C, hand-computed for both builds
    mul_op(8'd200, 8'd150, 8'd77,  30000, 30077, "basic");
    tick();
    check("basic pulse width", int'(o_mul_valid), 0);
    check("basic held", int'(o_product), ACC ? 30077 : 30000);

    mul_op(8'd7,   8'd13,  8'd5,   91,    96,    "divider");
    mul_op(8'd255, 8'd255, 8'd255, 65025, 65280, "max");
    mul_op(8'd0,   8'd255, 8'd9,   0,     9,     "zero A");
    mul_op(8'd255, 8'd0,   8'd9,   0,     9,     "zero B");
    mul_op(8'd1,   8'd1,   8'd0,   1,     1,     "unit");
    tick();

    // Busy drop: second request at T+4 is ignored
    i_multiplicand = 8'd3;
    i_multiplier   = 8'd4;
    i_addend       = 8'd0;
    i_mul_valid    = 1'b1;
    tick();
    i_mul_valid = 1'b0;
    repeat (3) tick();
    i_multiplicand = 8'd9;
    i_multiplier   = 8'd9;
    i_mul_valid    = 1'b1;
    tick();
    i_mul_valid = 1'b0;
    wait_result(5, lat, busy_ok);
    check("drop latency", lat, 10);
    check("drop busy", int'(busy_ok), 1);
    check("drop product", int'(o_product), 12);

    // Back-to-back: accepted in the cycle the previous result appears
    mul_op(8'd2, 8'd5, 8'd0, 10, 10, "back2back");
    tick();
    check("b2b held", int'(o_product), 10);

    // Reset mid-operation at T+5
    i_multiplicand = 8'd100;
    i_multiplier   = 8'd100;
    i_mul_valid    = 1'b1;
    tick();
    i_mul_valid = 1'b0;
    repeat (4) tick();
    i_rstp = 1'b1;
    tick();
    i_rstp = 1'b0;
    check("abort ready", int'(o_ready), 1);
    check("abort product", int'(o_product), 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_mul_valid) pulses++;
      tick();
    end
    check("abort no result", pulses, 0);
    mul_op(8'd6, 8'd7, 8'd0, 42, 42, "after abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
